ecg_moving_avg: RTL
===================

Name: ecg_moving_avg

Overview:
Dual-window moving-average stage for the ECG R-peak path. It consumes the raw signed ECG sample stream and produces a short-window and a long-window running mean, each with its own valid flag. It also outputs the sample aligned with those means. The outputs feed the absolute-difference stage directly, port-for-port.

Parameters:
DATA_WIDTH, 11, signed sample width (two's complement).
SHORT_LOG2, 3, log2 of short window length (Ns = 8).
LONG_LOG2, 6, log2 of long window length (Nl = 64); SHORT_LOG2 < LONG_LOG2 required (elaboration-time check).

Ports:
i_clk  in  1  clock.
i_nrst  in  1  reset: synchronous and active-low.
i_ce  in  1  sample strobe; one new sample per cycle with i_ce=1.
i_ecg_sample  in  DATA_WIDTH signed  input ECG sample.
o_ecg_sample  out  DATA_WIDTH signed  sample aligned with the current averages.
o_ma_short  out  DATA_WIDTH signed  short-window mean.
o_ma_long  out  DATA_WIDTH signed  long-window mean.
o_ma_short_valid  out  1  short window completely filled.
o_ma_long_valid  out  1  long window completely filled.

Behaviour:
- Reset (i_nrst=0 at posedge):
  - All outputs go to 0.
  - Write pointer, fill counter and both accumulators are cleared.
  - Buffer contents are not cleared; they are masked by the fill counter.
  - Reset dominates i_ce.
- Storage:
  - Circular buffer of Nl entries of DATA_WIDTH bits.
  - Write pointer is LONG_LOG2 bits and wraps naturally from Nl-1 to 0.
- Per i_ce=1 cycle, with x = i_ecg_sample and cnt = fill count before this sample:
  - old_s = buf[wr_ptr - Ns] if cnt >= Ns, else 0. Pointer arithmetic is modulo Nl.
  - old_l = buf[wr_ptr] if cnt >= Nl, else 0. This entry is overwritten in the same cycle, so it must be read before the write.
  - acc_s <= acc_s + x - old_s.
  - acc_l <= acc_l + x - old_l.
  - buf[wr_ptr] <= x; wr_ptr++.
  - cnt <= min(cnt+1, Nl); the counter saturates and never wraps.
- Accumulator widths: acc_s is DATA_WIDTH+SHORT_LOG2 signed; acc_l is DATA_WIDTH+LONG_LOG2 signed. No overflow is possible by construction.
- Output registers, updated only on i_ce=1 cycles (latency 1 clock from the i_ce sample):
  - o_ma_short = (acc_s + x - old_s) >>> SHORT_LOG2, i.e. arithmetic shift, rounding toward -inf. Result is truncated to DATA_WIDTH, which is lossless.
  - o_ma_long is computed the same way using LONG_LOG2.
  - o_ecg_sample = x.
  - o_ma_short_valid = (cnt+1 >= Ns).
  - o_ma_long_valid = (cnt+1 >= Nl).
  - Once set, a valid flag stays 1 until reset.
- Fill phase: the averages are still output but are partial sums divided by N. Downstream must ignore them while the corresponding valid is 0.
- i_ce=0: all outputs, pointer, counter and accumulators hold.
- Back-to-back i_ce: full throughput, one sample per clock, no stall.
- Reset mid-fill or mid-run: the next sample after reset starts a fresh fill. Stale buffer data must not appear in any output.
- No handshake back-pressure; the stream is strictly i_ce-paced.

Test Plan:
- Reset, then 70 samples of constant 100 with continuous i_ce:
  - o_ma_short after sample k (k=1..8) is floor(100k/8); 100 with short_valid=1 at k=8.
  - o_ma_long = 100 with long_valid=1 exactly at k=64; long_valid=0 at k=63.
- 64 samples of 0, then a step to 800:
  - After 4 step samples: o_ma_short=400, o_ma_long=50.
  - After 8 step samples: o_ma_short=800, o_ma_long=100.
  - After 64 step samples: o_ma_long=800.
- Rounding and sign: after the window is filled with 0, send one sample of -1 → o_ma_short=-1 and o_ma_long=-1 (floor); o_ecg_sample=-1. Seven further 0 samples → o_ma_short stays -1 until the -1 leaves the window, then returns to 0.
- Extremes:
  - 64 samples of +1023 → o_ma_long=1023, o_ma_short=1023.
  - Then 64 samples of -1024 → both averages -1024; no wrap or glitch.
- i_ce gaps: random i_ce duty of 30% with a ramp input → results bit-exact against a reference model indexed by strobe count, and outputs constant during every i_ce=0 cycle.
- Reset asserted after 40 samples of 500, then 8 samples of 0 → all outputs 0 on reset; short_valid=1 with o_ma_short=0 at the 8th sample; long_valid=0; no trace of 500 in o_ma_long.

Source files
------------

// File: rtl/ecg_moving_avg.sv
// Dual-window running mean for the ECG R-peak path: short and long means
// computed from one shared circular sample buffer, with sticky fill flags.
module ecg_moving_avg #(
    parameter int DATA_WIDTH = 11,
    parameter int SHORT_LOG2 = 3,
    parameter int LONG_LOG2  = 6
) (
    input  logic                         i_clk,
    input  logic                         i_nrst,
    input  logic                         i_ce,
    input  logic signed [DATA_WIDTH-1:0] i_ecg_sample,
    output logic signed [DATA_WIDTH-1:0] o_ecg_sample,
    output logic signed [DATA_WIDTH-1:0] o_ma_short,
    output logic signed [DATA_WIDTH-1:0] o_ma_long,
    output logic                         o_ma_short_valid,
    output logic                         o_ma_long_valid
);

    localparam int NS      = 1 << SHORT_LOG2;
    localparam int NL      = 1 << LONG_LOG2;
    localparam int ACC_S_W = DATA_WIDTH + SHORT_LOG2;
    localparam int ACC_L_W = DATA_WIDTH + LONG_LOG2;

    localparam logic [LONG_LOG2:0]   CNT_NS  = (LONG_LOG2 + 1)'(NS);
    localparam logic [LONG_LOG2:0]   CNT_NL  = (LONG_LOG2 + 1)'(NL);
    localparam logic [LONG_LOG2:0]   CNT_ONE = (LONG_LOG2 + 1)'(1);
    localparam logic [LONG_LOG2-1:0] PTR_NS  = LONG_LOG2'(NS);
    localparam logic [LONG_LOG2-1:0] PTR_ONE = LONG_LOG2'(1);

    generate
        if (SHORT_LOG2 >= LONG_LOG2) begin : g_bad_cfg
            $error("ecg_moving_avg: SHORT_LOG2 must be smaller than LONG_LOG2");
        end
    endgenerate

    function automatic logic signed [ACC_S_W-1:0] sext_s(input logic signed [DATA_WIDTH-1:0] v);
        return {{SHORT_LOG2{v[DATA_WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [ACC_L_W-1:0] sext_l(input logic signed [DATA_WIDTH-1:0] v);
        return {{LONG_LOG2{v[DATA_WIDTH-1]}}, v};
    endfunction

    // Arithmetic shift floors toward -inf; the quotient always fits DATA_WIDTH.
    function automatic logic signed [DATA_WIDTH-1:0] mean_s(input logic signed [ACC_S_W-1:0] a);
        logic signed [ACC_S_W-1:0] sh;
        sh = a >>> SHORT_LOG2;
        return sh[DATA_WIDTH-1:0];
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] mean_l(input logic signed [ACC_L_W-1:0] a);
        logic signed [ACC_L_W-1:0] sh;
        sh = a >>> LONG_LOG2;
        return sh[DATA_WIDTH-1:0];
    endfunction

    logic signed [DATA_WIDTH-1:0] ring [NL];
    logic        [LONG_LOG2-1:0]  wr_ptr;
    logic        [LONG_LOG2:0]    cnt;
    logic signed [ACC_S_W-1:0]    acc_s;
    logic signed [ACC_L_W-1:0]    acc_l;

    logic        [LONG_LOG2-1:0]  rd_s_idx_p0;
    logic signed [DATA_WIDTH-1:0] old_s_p0;
    logic signed [DATA_WIDTH-1:0] old_l_p0;
    logic signed [ACC_S_W-1:0]    sum_s_p0;
    logic signed [ACC_L_W-1:0]    sum_l_p0;
    logic        [LONG_LOG2:0]    cnt_nxt_p0;

    // Stage p0: leaving samples are read before the write; the fill count masks stale entries.
    always_comb begin
        rd_s_idx_p0 = wr_ptr - PTR_NS;
        old_s_p0    = (cnt >= CNT_NS) ? ring[rd_s_idx_p0] : '0;
        old_l_p0    = (cnt >= CNT_NL) ? ring[wr_ptr] : '0;
        sum_s_p0    = acc_s + sext_s(i_ecg_sample) - sext_s(old_s_p0);
        sum_l_p0    = acc_l + sext_l(i_ecg_sample) - sext_l(old_l_p0);
        cnt_nxt_p0  = (cnt == CNT_NL) ? cnt : cnt + CNT_ONE;
    end

    always_ff @(posedge i_clk) begin
        if (i_ce) begin
            ring[wr_ptr] <= i_ecg_sample;
        end
    end

    // Stage p1: registered means and flags, updated only on strobe cycles.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            wr_ptr           <= '0;
            cnt              <= '0;
            acc_s            <= '0;
            acc_l            <= '0;
            o_ecg_sample     <= '0;
            o_ma_short       <= '0;
            o_ma_long        <= '0;
            o_ma_short_valid <= 1'b0;
            o_ma_long_valid  <= 1'b0;
        end else if (i_ce) begin
            wr_ptr           <= wr_ptr + PTR_ONE;
            cnt              <= cnt_nxt_p0;
            acc_s            <= sum_s_p0;
            acc_l            <= sum_l_p0;
            o_ecg_sample     <= i_ecg_sample;
            o_ma_short       <= mean_s(sum_s_p0);
            o_ma_long        <= mean_l(sum_l_p0);
            o_ma_short_valid <= (cnt_nxt_p0 >= CNT_NS);
            o_ma_long_valid  <= (cnt_nxt_p0 >= CNT_NL);
        end
    end

endmodule
